// File: rtl/hazard_unit.sv
// hazard_unit: load-use/branch hazard detection, stall FSM, IF/ID flush and event counters
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             branch_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_write_addr,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_write_addr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             hazard_detected,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t state;
  logic rem;
  logic ex_m, mem_m, stall;
  logic [1:0] n;
  // required stall length from the ID operands against the EX and MEM destinations
  always_comb begin
    ex_m  = (id_uses_rs & (id_rs == ex_write_addr) & |ex_write_addr) |
            (id_uses_rt & (id_rt == ex_write_addr) & |ex_write_addr);
    mem_m = (id_uses_rs & (id_rs == mem_write_addr) & |mem_write_addr) |
            (id_uses_rt & (id_rt == mem_write_addr) & |mem_write_addr);
    n = (ex_mem_read & ex_m & id_branch) ? 2'd2 :
        ((ex_mem_read & ex_m) | (ex_reg_write & ~ex_mem_read & ex_m & id_branch) |
         (mem_mem_read & mem_m & id_branch)) ? 2'd1 : 2'd0;
    stall = ~reset & ((state == STALL) | (n != 2'd0));
  end
  // Mealy pipeline controls; reset forces the idle values
  always_comb begin
    pc_write        = ~stall;
    ifid_write      = ~stall;
    hazard_detected = stall;
    stall_active    = ~reset & (state == STALL);
    ifid_flush      = ~reset & (state == IDLE) & (n == 2'd0) & (id_jump | (id_branch & branch_taken));
  end
  // two-cycle stall sequencing: STALL ignores inputs and returns once rem runs out
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem   <= 1'b0;
    end else if (state == IDLE) begin
      if (n == 2'd2) begin
        state <= STALL;
        rem   <= 1'b1;
      end
    end else begin
      rem   <= rem - 1'b1;
      state <= (rem == 1'b1) ? IDLE : STALL;
    end
  end
  // saturating event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (hazard_detected && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (ifid_flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of stall, flush, reset and counter behaviour
module tb_hazard_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs, id_rt, ex_write_addr, mem_write_addr;
  logic id_uses_rs, id_uses_rt, id_branch, id_jump, branch_taken;
  logic ex_mem_read, ex_reg_write, mem_mem_read;
  logic pc_write, ifid_write, ifid_flush, hazard_detected, stall_active;
  logic [31:0] stall_count, flush_count;
  logic pc_write4, ifid_write4, ifid_flush4, hazard_detected4, stall_active4;
  logic [3:0] stall_count4, flush_count4;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hazard_unit dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
    .id_jump(id_jump), .branch_taken(branch_taken), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_write_addr(ex_write_addr),
    .mem_mem_read(mem_mem_read), .mem_write_addr(mem_write_addr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .hazard_detected(hazard_detected), .stall_active(stall_active),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
    .id_jump(id_jump), .branch_taken(branch_taken), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_write_addr(ex_write_addr),
    .mem_mem_read(mem_mem_read), .mem_write_addr(mem_write_addr),
    .pc_write(pc_write4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
    .hazard_detected(hazard_detected4), .stall_active(stall_active4),
    .stall_count(stall_count4), .flush_count(flush_count4)
  );

  task automatic clear_inputs;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_branch = 1'b0; id_jump = 1'b0; branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_write_addr = 5'd0;
    mem_mem_read = 1'b0; mem_write_addr = 5'd0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_load_use(input logic br);
    ex_mem_read = 1'b1; ex_write_addr = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; id_branch = br;
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1;
    set_load_use(1'b1);
    id_jump = 1'b1;
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write got %0b exp 1", pc_write); end
    checks++; if (ifid_write !== 1'b1) begin errors++; $display("FAIL rst_ifid_write got %0b exp 1", ifid_write); end
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL rst_hazard got %0b exp 0", hazard_detected); end
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0b exp 0", ifid_flush); end
    checks++; if (stall_active !== 1'b0) begin errors++; $display("FAIL rst_stall_active got %0b exp 0", stall_active); end
    @(posedge clock); #1;
    checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", stall_count, flush_count); end
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_load_use;
    do_reset();
    set_load_use(1'b0);
    #1;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL lu_pc_write got %0b exp 0", pc_write); end
    checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL lu_ifid_write got %0b exp 0", ifid_write); end
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL lu_hazard got %0b exp 1", hazard_detected); end
    checks++; if (stall_active !== 1'b0) begin errors++; $display("FAIL lu_stall_active got %0b exp 0", stall_active); end
    @(negedge clock);
    clear_inputs();
    mem_mem_read = 1'b1; mem_write_addr = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_next_pc_write got %0b exp 1", pc_write); end
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_stall_count got %0d exp 1", stall_count); end
    @(posedge clock); #1;
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_stall_count_hold got %0d exp 1", stall_count); end
  endtask

  task automatic test_load_branch;
    do_reset();
    set_load_use(1'b1);
    branch_taken = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b1 || pc_write !== 1'b0) begin errors++; $display("FAIL lb_c1 got hz=%0b pc=%0b exp hz=1 pc=0", hazard_detected, pc_write); end
    checks++; if (stall_active !== 1'b0) begin errors++; $display("FAIL lb_c1_active got %0b exp 0", stall_active); end
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL lb_c1_flush got %0b exp 0", ifid_flush); end
    @(negedge clock);
    clear_inputs();
    #1;
    checks++; if (hazard_detected !== 1'b1 || pc_write !== 1'b0) begin errors++; $display("FAIL lb_c2 got hz=%0b pc=%0b exp hz=1 pc=0", hazard_detected, pc_write); end
    checks++; if (stall_active !== 1'b1) begin errors++; $display("FAIL lb_c2_active got %0b exp 1", stall_active); end
    @(negedge clock);
    id_branch = 1'b1; branch_taken = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b0 || stall_active !== 1'b0) begin errors++; $display("FAIL lb_c3 got hz=%0b act=%0b exp 0/0", hazard_detected, stall_active); end
    checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL lb_c3_flush got %0b exp 1", ifid_flush); end
    checks++; if (stall_count !== 32'd2 || flush_count !== 32'd0) begin errors++; $display("FAIL lb_counts got %0d/%0d exp 2/0", stall_count, flush_count); end
    @(posedge clock); #1;
    checks++; if (flush_count !== 32'd1) begin errors++; $display("FAIL lb_flush_count got %0d exp 1", flush_count); end
  endtask

  task automatic test_zero_unused;
    do_reset();
    ex_mem_read = 1'b1; ex_write_addr = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; id_branch = 1'b1;
    mem_mem_read = 1'b1; mem_write_addr = 5'd0;
    #1;
    checks++; if (hazard_detected !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL zero_reg got hz=%0b pc=%0b exp 0/1", hazard_detected, pc_write); end
    @(negedge clock);
    clear_inputs();
    ex_mem_read = 1'b1; ex_write_addr = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL unused_rt got %0b exp 0", hazard_detected); end
    id_uses_rt = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL used_rt got %0b exp 1", hazard_detected); end
    @(negedge clock);
    clear_inputs();
    ex_reg_write = 1'b1; ex_write_addr = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL alu_nobranch got %0b exp 0", hazard_detected); end
  endtask

  task automatic test_flush;
    do_reset();
    id_branch = 1'b1; branch_taken = 1'b1;
    #1;
    checks++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL br_flush got fl=%0b pc=%0b exp 1/1", ifid_flush, pc_write); end
    @(posedge clock); #1;
    checks++; if (flush_count !== 32'd1) begin errors++; $display("FAIL br_flush_count got %0d exp 1", flush_count); end
    @(negedge clock);
    clear_inputs();
    id_jump = 1'b1;
    #1;
    checks++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL j_flush got fl=%0b pc=%0b exp 1/1", ifid_flush, pc_write); end
    @(posedge clock); #1;
    checks++; if (flush_count !== 32'd2) begin errors++; $display("FAIL j_flush_count got %0d exp 2", flush_count); end
    @(negedge clock);
    clear_inputs();
    id_branch = 1'b1;
    #1;
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL nt_flush got %0b exp 0", ifid_flush); end
  endtask

  task automatic test_ex_mem_both;
    do_reset();
    ex_reg_write = 1'b1; ex_write_addr = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; id_branch = 1'b1;
    mem_mem_read = 1'b1; mem_write_addr = 5'd6; id_rt = 5'd6; id_uses_rt = 1'b1; branch_taken = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b1 || ifid_flush !== 1'b0) begin errors++; $display("FAIL both_c1 got hz=%0b fl=%0b exp 1/0", hazard_detected, ifid_flush); end
    @(negedge clock);
    clear_inputs();
    #1;
    checks++; if (hazard_detected !== 1'b0 || stall_active !== 1'b0) begin errors++; $display("FAIL both_c2 got hz=%0b act=%0b exp 0/0", hazard_detected, stall_active); end
    checks++; if (stall_count !== 32'd1 || flush_count !== 32'd0) begin errors++; $display("FAIL both_counts got %0d/%0d exp 1/0", stall_count, flush_count); end
  endtask

  task automatic test_reset_in_stall;
    do_reset();
    set_load_use(1'b1);
    @(negedge clock);
    #1;
    checks++; if (stall_active !== 1'b1) begin errors++; $display("FAIL rs_in_stall got %0b exp 1", stall_active); end
    reset = 1'b1;
    #1;
    checks++; if (pc_write !== 1'b1 || hazard_detected !== 1'b0 || stall_active !== 1'b0) begin errors++; $display("FAIL rs_outputs got pc=%0b hz=%0b act=%0b exp 1/0/0", pc_write, hazard_detected, stall_active); end
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (hazard_detected !== 1'b0 || stall_active !== 1'b0) begin errors++; $display("FAIL rs_residual got hz=%0b act=%0b exp 0/0", hazard_detected, stall_active); end
    @(posedge clock); #1;
    checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL rs_counts got %0d/%0d exp 0/0", stall_count, flush_count); end
  endtask

  task automatic test_saturation;
    do_reset();
    set_load_use(1'b0);
    repeat (20) @(posedge clock);
    #1;
    checks++; if (stall_count4 !== 4'd15) begin errors++; $display("FAIL sat_count4 got %0d exp 15", stall_count4); end
    checks++; if (stall_count !== 32'd20) begin errors++; $display("FAIL sat_count32 got %0d exp 20", stall_count); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_load_branch();
    test_zero_unused();
    test_flush();
    test_ex_mem_both();
    test_reset_in_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
